// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and command-master state encoding
package axi4_lite_pkg;

  localparam logic [1:0] AXI_RESP_OK     = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// rtl/axi4_lite_cmd_master.sv - single-outstanding AXI4-Lite master driven by a register command stream
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY
);

  state_t state, state_nxt;
  logic   ready_armed;
  logic   aw_done, w_done;
  logic   to_flag;
  logic   accept, aw_hs, w_hs, busy;

  // ready_armed keeps cmd_ready low while reset is held and releases it on the first clock after
  assign cmd_ready = (state == ST_IDLE) && ready_armed;
  assign accept    = cmd_valid && cmd_ready;

  assign AWVALID   = (state == ST_WR_AW_W) && !aw_done;
  assign WVALID    = (state == ST_WR_AW_W) && !w_done;
  assign BREADY    = (state == ST_WR_B);
  assign ARVALID   = (state == ST_RD_AR);
  assign RREADY    = (state == ST_RD_R);
  assign rsp_valid = (state == ST_RSP);
  assign rsp_timeout = to_flag;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign busy  = (state == ST_WR_AW_W) || (state == ST_WR_B) ||
                 (state == ST_RD_AR) || (state == ST_RD_R);

  // State register plus the post-reset arm bit for cmd_ready
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      ready_armed <= 1'b0;
    end else begin
      state       <= state_nxt;
      ready_armed <= 1'b1;
    end
  end

  // Next-state logic; AW and W may finish in either order or together
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (accept) state_nxt = cmd_write ? ST_WR_AW_W : ST_RD_AR;
      ST_WR_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_B;
      ST_WR_B:    if (BVALID) state_nxt = ST_RSP;
      ST_RD_AR:   if (ARREADY) state_nxt = ST_RD_R;
      ST_RD_R:    if (RVALID) state_nxt = ST_RSP;
      ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Per-channel completion flags so each write VALID drops right after its own handshake
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Address/data registers load only on acceptance; response fields load on B/R capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      AWADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
      ARADDR    <= '0;
      rsp_rdata <= '0;
      rsp_resp  <= AXI_RESP_OK;
    end else begin
      if (accept) begin
        if (cmd_write) begin
          AWADDR <= cmd_addr;
          WDATA  <= cmd_wdata;
          WSTRB  <= cmd_wstrb;
        end else begin
          ARADDR <= cmd_addr;
        end
      end
      if ((state == ST_WR_B) && BVALID) begin
        rsp_rdata <= '0;
        rsp_resp  <= BRESP;
      end
      if ((state == ST_RD_R) && RVALID) begin
        rsp_rdata <= RDATA;
        rsp_resp  <= RRESP;
      end
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
      logic [CW-1:0] wd_cnt;

      // Watchdog: saturating busy-cycle count, sticky flag once the limit is held
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          wd_cnt  <= '0;
          to_flag <= 1'b0;
        end else if (accept) begin
          wd_cnt  <= '0;
          to_flag <= 1'b0;
        end else if (busy) begin
          if (wd_cnt == LIMIT) to_flag <= 1'b1;
          else                 wd_cnt  <= wd_cnt + CW'(1);
        end
      end
    end else begin : g_no_wdog
      assign to_flag = 1'b0;
    end
  endgenerate

endmodule
